// File: rtl/noc_router_input.sv
// NoC router input stage: per-VC FIFOs fed from one link, with a per-VC route FSM
// that binds each buffered packet to a single output port until its last flit leaves.
module noc_router_input #(
  parameter int unsigned              FLIT_WIDTH   = 32,
  parameter int unsigned              VCHANNELS    = 7,
  parameter int unsigned              OUTPUTS      = 7,
  parameter int unsigned              DESTS        = 8,
  parameter logic [DESTS*OUTPUTS-1:0] ROUTES       = '0,
  parameter int unsigned              BUFFER_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [FLIT_WIDTH-1:0]                 in_flit,
  input  logic                                  in_last,
  input  logic [VCHANNELS-1:0]                  in_valid,
  output logic [VCHANNELS-1:0]                  in_ready,
  output logic [VCHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
  output logic [VCHANNELS-1:0]                  out_last,
  output logic [VCHANNELS-1:0][OUTPUTS-1:0]     out_valid,
  input  logic [VCHANNELS-1:0][OUTPUTS-1:0]     out_ready
);

  localparam int unsigned DEST_WIDTH = (DESTS > 1) ? $clog2(DESTS) : 1;
  localparam int unsigned PTR_W      = $clog2(BUFFER_DEPTH);
  localparam int unsigned CNT_W      = $clog2(BUFFER_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_e;

  logic [FLIT_WIDTH:0]  mem_q       [VCHANNELS][BUFFER_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q    [VCHANNELS];
  logic [PTR_W-1:0]     rd_ptr_q    [VCHANNELS];
  logic [CNT_W-1:0]     count_q     [VCHANNELS];
  state_e               state_q     [VCHANNELS];
  state_e               state_d     [VCHANNELS];
  logic [OUTPUTS-1:0]   cur_route_q [VCHANNELS];
  logic [OUTPUTS-1:0]   cur_route_d [VCHANNELS];

  logic [FLIT_WIDTH:0]  head        [VCHANNELS];
  logic [VCHANNELS-1:0] nonempty;
  logic [VCHANNELS-1:0] not_full;
  logic [VCHANNELS-1:0] push;
  logic [VCHANNELS-1:0] pop;
  logic [VCHANNELS-1:0] lowest;
  logic                 multi_hot;

  // in_ready comes from the registered count only; a multi-hot in_valid is
  // narrowed to its lowest set VC so at most one FIFO is ever written.
  always_comb begin
    for (int unsigned v = 0; v < VCHANNELS; v++) begin
      head[v]     = mem_q[v][rd_ptr_q[v]];
      nonempty[v] = (count_q[v] != '0);
      not_full[v] = (count_q[v] != CNT_W'(BUFFER_DEPTH));
    end
    lowest    = in_valid & (~in_valid + VCHANNELS'(1));
    multi_hot = ((in_valid & (in_valid - VCHANNELS'(1))) != '0);
    in_ready  = not_full & (multi_hot ? lowest : '1) & {VCHANNELS{~rst}};
    push      = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < VCHANNELS; v++) begin
      if (push[v]) mem_q[v][wr_ptr_q[v]] <= {in_last, in_flit};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned v = 0; v < VCHANNELS; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < VCHANNELS; v++) begin
        if (push[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PTR_W'(1);
        if (pop[v])  rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
        case ({push[v], pop[v]})
          2'b10:   count_q[v] <= count_q[v] + CNT_W'(1);
          2'b01:   count_q[v] <= count_q[v] - CNT_W'(1);
          default: count_q[v] <= count_q[v];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned v = 0; v < VCHANNELS; v++) begin
        state_q[v]     <= IDLE;
        cur_route_q[v] <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < VCHANNELS; v++) begin
        state_q[v]     <= state_d[v];
        cur_route_q[v] <= cur_route_d[v];
      end
    end
  end

  // Route lookup scans the table so an out-of-range dest yields a zero entry.
  always_comb begin
    logic [DEST_WIDTH-1:0] dest;
    logic [OUTPUTS-1:0]    entry;
    for (int unsigned v = 0; v < VCHANNELS; v++) begin
      state_d[v]     = state_q[v];
      cur_route_d[v] = cur_route_q[v];
      dest           = head[v][FLIT_WIDTH-1 -: DEST_WIDTH];
      entry          = '0;
      for (int unsigned d = 0; d < DESTS; d++) begin
        if (dest == DEST_WIDTH'(d)) entry = ROUTES[d*OUTPUTS +: OUTPUTS];
      end
      case (state_q[v])
        IDLE: begin
          if (nonempty[v]) begin
            if (entry != '0) begin
              cur_route_d[v] = entry;
              state_d[v]     = ACTIVE;
            end else begin
              state_d[v] = DROP;
            end
          end
        end
        ACTIVE, DROP: begin
          if (pop[v] && head[v][FLIT_WIDTH]) state_d[v] = IDLE;
        end
        default: state_d[v] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int unsigned v = 0; v < VCHANNELS; v++) begin
      out_flit[v]  = head[v][FLIT_WIDTH-1:0];
      out_last[v]  = nonempty[v] & head[v][FLIT_WIDTH];
      out_valid[v] = '0;
      pop[v]       = 1'b0;
      case (state_q[v])
        ACTIVE: begin
          out_valid[v] = cur_route_q[v] & {OUTPUTS{nonempty[v]}};
          pop[v]       = nonempty[v] && ((cur_route_q[v] & out_ready[v]) != '0);
        end
        DROP:    pop[v] = nonempty[v];
        default: pop[v] = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/noc_router_input.md
Name: noc_router_input

Overview:
- Input stage of a virtual-channel NoC router; the receive end of a physical link driven by the router output stage of a neighbouring router.
- Takes one flit bus with per-VC valid/ready and steers each flit into a per-VC FIFO.
- Decodes each packet's header destination through a static route table.
- Presents each VC's packet to exactly one router output port until the last flit has left.

Parameters:
- FLIT_WIDTH, 32, flit width in bits.
- VCHANNELS, 7, number of virtual channels.
- OUTPUTS, 7, number of router output ports.
- DESTS, 8, number of destinations; DEST_WIDTH = $clog2(DESTS), minimum 1.
- ROUTES, {DESTS*OUTPUTS{1'b0}}, flattened route table; bits [d*OUTPUTS +: OUTPUTS] hold the one-hot output port for destination d.
- BUFFER_DEPTH, 4, per-VC FIFO depth; must be a power of two and at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_flit  input  FLIT_WIDTH  link flit
- in_last  input  1  link flit is the last flit of its packet
- in_valid  input  VCHANNELS  per-VC valid; one-hot or zero
- in_ready  output  VCHANNELS  per-VC ready
- out_flit  output  [VCHANNELS][FLIT_WIDTH]  head flit of each VC FIFO
- out_last  output  VCHANNELS  head flit of each VC is a last flit
- out_valid  output  [VCHANNELS][OUTPUTS]  per-VC, per-output valid; at most one bit set per VC
- out_ready  input  [VCHANNELS][OUTPUTS]  per-VC, per-output ready

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All FIFOs empty; pointers and counts cleared.
  - All route FSMs in IDLE; cur_route cleared.
  - in_ready = 0 while rst is high, all 1 on the first cycle after release.
  - out_valid = 0, out_last = 0; out_flit is don't-care.
  - Reset mid-packet discards all buffered flits and any in-progress route; no flit appears afterwards.
- Link acceptance:
  - in_ready[v] = (count[v] != BUFFER_DEPTH), taken from the registered count only.
  - A pop in the same cycle does not free a slot for a push in that cycle.
  - A push to VC v occurs when in_valid[v] && in_ready[v]; {in_last, in_flit} are written at the tail.
  - Multi-hot in_valid is a protocol violation. Only the lowest set index is accepted; in_ready of every other VC is forced to 0 that cycle.
- FIFO:
  - Circular buffer with a log2(BUFFER_DEPTH)-bit pointer that wraps naturally.
  - Count is 0..BUFFER_DEPTH. Simultaneous push and pop leaves count unchanged.
  - out_flit[v] and out_last[v] show the head entry combinationally.
- Route FSM, one per VC, states IDLE / ACTIVE / DROP:
  - IDLE with FIFO non-empty: dest = head[FLIT_WIDTH-1 -: DEST_WIDTH].
    - If dest < DESTS and the route table entry is non-zero: latch cur_route and go to ACTIVE.
    - Otherwise go to DROP.
    - No pop occurs in IDLE.
  - ACTIVE: out_valid[v] = cur_route & {OUTPUTS{non-empty}}.
    - Pop when (cur_route & out_ready[v]) != 0 and the FIFO is non-empty.
    - Popping a flit with last=1 returns to IDLE.
  - DROP: pop one flit per cycle while non-empty, out_valid = 0. Popping last=1 returns to IDLE.
  - out_ready on non-selected outputs is ignored.
- Latency and throughput:
  - A flit pushed in cycle t is at the head in t+1, route latched at the end of t+1, out_valid in t+2.
  - Within a packet: one flit per cycle per VC.
  - Between packets on the same VC: exactly one idle cycle (the lookup).
  - Single-flit packet: enters ACTIVE, one pop, back to IDLE.
  - VCs are fully independent; VCs in ACTIVE may target the same output concurrently. Output arbitration is downstream.
- Underrun: ACTIVE with an empty FIFO holds out_valid = 0 and keeps cur_route.

Test Plan:
- Reset release, ROUTES routes dest 3 to output 2 (bit 2), 3-flit packet on VC1 with head[31:29]=3 and all out_ready=1 -> in_ready=7'h7F, head pushed cycle 0, out_valid[1]=7'b0000100 from cycle 2, flits popped cycles 2,3,4 in order, out_last[1]=1 only on the third.
- VC0 with out_ready[0]=0, push 5 flits of one packet back-to-back -> in_ready[0]=0 after the 4th push, 5th held. Then raise out_ready[0][route] -> FIFO drains, 5th flit accepted the cycle after the first pop.
- Two single-flit packets back-to-back on VC2 -> pops 2 cycles apart (one lookup bubble); out_valid[2] deasserted in the bubble cycle.
- Head with dest=7 where ROUTES entry 7=0, packet of 4 flits -> out_valid stays 0, 4 pops over 4 cycles in DROP, FSM returns to IDLE; the following valid packet is routed normally.
- in_valid=7'b0000110 for one cycle -> only VC1 pushed, in_ready[2]=0 that cycle, VC2 count unchanged.
- rst asserted asynchronously while VC3 holds 2 flits in ACTIVE -> out_valid cleared immediately, count[3]=0, FSM IDLE; after release, no stale flit is presented.
